lift_seq: RTL

LIFT_SEQ -- requirements
Module: lift_seq

---
 rtl/lift_seq.sv | 172 +++++++++++++++++
 1 files changed

// File: rtl/lift_seq.sv
// Two-pass in-place lifting sequencer: for each target sample it fetches the
// left/centre/right neighbours, hands them to an external lift unit and writes the result back.
module lift_seq #(
  parameter int DEPTH    = 64,
  parameter int WIDTH    = 16,
  parameter int LIFT_LAT = 1
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic                       start,
  input  logic                       fwd,
  output logic                       busy,
  output logic                       done,
  output logic [$clog2(DEPTH)-1:0]   rd_addr,
  output logic                       rd_en,
  input  logic [WIDTH-1:0]           rd_data,
  output logic [$clog2(DEPTH)-1:0]   wr_addr,
  output logic                       wr_dv,
  output logic [WIDTH-1:0]           wr_data,
  output logic signed [WIDTH-1:0]    l_s,
  output logic signed [WIDTH-1:0]    s_s,
  output logic signed [WIDTH-1:0]    r_s,
  output logic                       e_o_s,
  output logic                       f_i_s,
  input  logic signed [WIDTH-1:0]    res_s
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = (LIFT_LAT > 1) ? $clog2(LIFT_LAT) : 1;
  localparam logic [AW-1:0] LAST = AW'(DEPTH - 1);

  typedef enum logic [2:0] {
    IDLE, RD_L, RD_S, RD_R, CAP, LIFT, WRITE, DONE
  } state_e;

  state_e                 state_q;
  logic [AW-1:0]          tgt_q, tgt_d;
  logic [LW-1:0]          lat_q;
  logic                   pass_q;
  logic                   fwd_q;
  logic                   eo_q;
  logic                   busy_q, done_q;
  logic                   rd_en_q, wr_dv_q;
  logic [AW-1:0]          rd_addr_q, wr_addr_q;
  logic signed [WIDTH-1:0] l_q, s_q, r_q;
  logic                   last_tgt;

  // Edge mirroring: the missing neighbour is replaced by the inner one.
  function automatic logic [AW-1:0] left_of(input logic [AW-1:0] t);
    return (t == '0) ? AW'(1) : t - AW'(1);
  endfunction

  function automatic logic [AW-1:0] right_of(input logic [AW-1:0] t);
    return (t == LAST) ? LAST - AW'(1) : t + AW'(1);
  endfunction

  assign last_tgt = eo_q ? (tgt_q == LAST - AW'(1)) : (tgt_q == LAST);

  always_comb begin
    tgt_d = tgt_q + AW'(2);
    if (last_tgt) begin
      tgt_d = AW'(eo_q);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      tgt_q     <= '0;
      lat_q     <= '0;
      pass_q    <= 1'b0;
      fwd_q     <= 1'b0;
      eo_q      <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      rd_en_q   <= 1'b0;
      wr_dv_q   <= 1'b0;
      rd_addr_q <= '0;
      wr_addr_q <= '0;
      l_q       <= '0;
      s_q       <= '0;
      r_q       <= '0;
    end else begin
      rd_en_q <= 1'b0;
      wr_dv_q <= 1'b0;
      done_q  <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (start) begin
            fwd_q     <= fwd;
            eo_q      <= ~fwd;
            pass_q    <= 1'b0;
            tgt_q     <= AW'(fwd);
            busy_q    <= 1'b1;
            rd_en_q   <= 1'b1;
            rd_addr_q <= left_of(AW'(fwd));
            state_q   <= RD_L;
          end
        end
        RD_L: begin
          rd_en_q   <= 1'b1;
          rd_addr_q <= tgt_q;
          state_q   <= RD_S;
        end
        RD_S: begin
          l_q       <= $signed(rd_data);
          rd_en_q   <= 1'b1;
          rd_addr_q <= right_of(tgt_q);
          state_q   <= RD_R;
        end
        RD_R: begin
          s_q     <= $signed(rd_data);
          state_q <= CAP;
        end
        CAP: begin
          r_q     <= $signed(rd_data);
          lat_q   <= '0;
          state_q <= LIFT;
        end
        LIFT: begin
          if (lat_q == LW'(LIFT_LAT - 1)) begin
            wr_dv_q   <= 1'b1;
            wr_addr_q <= tgt_q;
            state_q   <= WRITE;
          end else begin
            lat_q <= lat_q + LW'(1);
          end
        end
        WRITE: begin
          if (last_tgt && pass_q) begin
            done_q  <= 1'b1;
            state_q <= DONE;
          end else begin
            // Crossing into the second pass flips the pass type on the same
            // edge that enters RD_L, so e_o_s is correct for the first read.
            if (last_tgt) begin
              pass_q <= 1'b1;
              eo_q   <= ~eo_q;
            end
            tgt_q     <= tgt_d;
            rd_en_q   <= 1'b1;
            rd_addr_q <= left_of(tgt_d);
            state_q   <= RD_L;
          end
        end
        DONE: begin
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: begin
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign busy    = busy_q;
  assign done    = done_q;
  assign rd_en   = rd_en_q;
  assign rd_addr = rd_addr_q;
  assign wr_dv   = wr_dv_q;
  assign wr_addr = wr_addr_q;
  // The lift result only becomes valid in WRITE, so it is forwarded rather than registered.
  assign wr_data = wr_dv_q ? $unsigned(res_s) : '0;
  assign l_s     = l_q;
  assign s_s     = s_q;
  assign r_s     = r_q;
  assign e_o_s   = eo_q;
  assign f_i_s   = fwd_q;

endmodule
